// File: rtl/rst_seq_gen.sv
// Purpose: multi-domain reset sequencer; power-on hold, ordered per-domain release, handshaked soft re-reset of a domain subset.
// Latency: rstn_o[k] releases INIT_DLY + k*STEP_DLY edges after rstn deasserts; soft domains are held SOFT_HOLD edges, then released STEP_DLY apart.
// Backpressure: soft_req_i is a level that is accepted only in RUN; it stays pending elsewhere and must drop before another request is seen.
module rst_seq_gen #(
    parameter int N_RST     = 4,
    parameter int CNT_W     = 16,
    parameter int INIT_DLY  = 100,
    parameter int STEP_DLY  = 16,
    parameter int SOFT_HOLD = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             soft_req_i,
    input  logic [N_RST-1:0] soft_mask_i,
    output logic [N_RST-1:0] rstn_o,
    output logic             all_rel_o,
    output logic             busy_o,
    output logic             soft_ack_o
);

    localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;

    // Counter values on which the current delay expires (counter holds edges seen minus one).
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DLY - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_RST - 1);

    typedef enum logic [2:0] {
        ST_PWR_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_SOFT_HOLD,
        ST_SOFT_REL,
        ST_WAIT_LOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_RST-1:0] pend_q, pend_d, pend_clr;
    logic [N_RST-1:0] rst_q, rst_d;
    logic             all_rel_q, all_rel_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic [IDX_W-1:0] low_idx;

    // Find the lowest soft-reset domain still held low, and the pending set once it is released.
    always_comb begin
        low_idx = '0;
        for (int i = N_RST - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        pend_clr          = pend_q;
        pend_clr[low_idx] = 1'b0;
        // Saturating increment so a long stay in one state cannot wrap the counter.
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        idx_d   = idx_q;
        pend_d  = pend_q;
        rst_d   = rst_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_PWR_HOLD: begin
                if (cnt_q == INIT_LAST) begin
                    rst_d[0] = 1'b1;
                    cnt_d    = '0;
                    if (N_RST == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STEP_LAST) begin
                    rst_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (soft_req_i) begin
                    pend_d = soft_mask_i;
                    rst_d  = rst_q & ~soft_mask_i;
                    if (soft_mask_i == '0) begin
                        // Nothing to reset: complete the handshake immediately.
                        ack_d   = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end else begin
                        state_d = ST_SOFT_HOLD;
                    end
                end
            end
            ST_SOFT_HOLD, ST_SOFT_REL: begin
                if (((state_q == ST_SOFT_HOLD) && (cnt_q == HOLD_LAST)) ||
                    ((state_q == ST_SOFT_REL) && (cnt_q == STEP_LAST))) begin
                    rst_d[low_idx] = 1'b1;
                    pend_d         = pend_clr;
                    cnt_d          = '0;
                    if (pend_clr == '0) begin
                        ack_d   = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end else begin
                        state_d = ST_SOFT_REL;
                    end
                end
            end
            ST_WAIT_LOW: begin
                cnt_d = '0;
                // A still-held request must be seen low before another one can start.
                if (!soft_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_PWR_HOLD;
                cnt_d   = '0;
                rst_d   = '0;
            end
        endcase

        busy_d    = (state_d != ST_RUN);
        all_rel_d = &rst_d;
    end

    // State and output registers; reset aborts any sequence in flight without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_PWR_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            rst_q     <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            rst_q     <= rst_d;
            all_rel_q <= all_rel_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign rstn_o     = rst_q;
    assign all_rel_o  = all_rel_q;
    assign busy_o     = busy_q;
    assign soft_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Purpose: directed bench for rst_seq_gen with default parameters.
// Latency: expectations are indexed by rising-edge number after rstn release or after soft-request acceptance.
// Backpressure: soft_req_i is held until soft_ack_o and dropped explicitly by each sequence.
module tb_rst_seq_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic       soft_req_i;
    logic [3:0] soft_mask_i;
    logic [3:0] rstn_o;
    logic       all_rel_o;
    logic       busy_o;
    logic       soft_ack_o;

    rst_seq_gen #(
        .N_RST    (4),
        .CNT_W    (16),
        .INIT_DLY (100),
        .STEP_DLY (16),
        .SOFT_HOLD(8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .soft_req_i (soft_req_i),
        .soft_mask_i(soft_mask_i),
        .rstn_o     (rstn_o),
        .all_rel_o  (all_rel_o),
        .busy_o     (busy_o),
        .soft_ack_o (soft_ack_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         off;
        logic [3:0] rst;
        logic       all_rel;
        logic       busy;
        logic       ack;
    } vec_t;

    vec_t       por_tbl[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         edge_n   = 0;
    int         ack_cnt  = 0;
    logic [3:0] and_acc  = 4'hF;

    // One rising edge, then observe on the following falling edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (soft_ack_o) ack_cnt++;
        and_acc &= rstn_o;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int base, input string tag);
        while (edge_n < base + v.off) tick();
        chk($sformatf("%s@%0d rstn_o", tag, v.off), 32'(rstn_o), 32'(v.rst));
        chk($sformatf("%s@%0d all_rel_o", tag, v.off), 32'(all_rel_o), 32'(v.all_rel));
        chk($sformatf("%s@%0d busy_o", tag, v.off), 32'(busy_o), 32'(v.busy));
        chk($sformatf("%s@%0d soft_ack_o", tag, v.off), 32'(soft_ack_o), 32'(v.ack));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("reset rstn_o", 32'(rstn_o), 32'h0);
        chk("reset all_rel_o", 32'(all_rel_o), 32'h0);
        chk("reset busy_o", 32'(busy_o), 32'h1);
        chk("reset soft_ack_o", 32'(soft_ack_o), 32'h0);
        repeat (3) tick();
        rstn   = 1'b1;
        edge_n = 0;
    endtask

    task automatic run_por(input string tag);
        foreach (por_tbl[i]) apply(por_tbl[i], 0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   e;
        bit   req_set;
        vec_t v;

        por_tbl.push_back('{1,   4'b0000, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{99,  4'b0000, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{100, 4'b0001, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{115, 4'b0001, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{116, 4'b0011, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{131, 4'b0011, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{132, 4'b0111, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{147, 4'b0111, 1'b0, 1'b1, 1'b0});
        por_tbl.push_back('{148, 4'b1111, 1'b1, 1'b0, 1'b0});

        rstn        = 1'b0;
        soft_req_i  = 1'b0;
        soft_mask_i = 4'h0;
        @(negedge clk);

        // Power-on release with default delays.
        do_reset();
        run_por("por1");
        while (edge_n < 160) tick();
        chk("por1 idle busy_o", 32'(busy_o), 32'h0);
        chk("por1 no ack", 32'(ack_cnt), 32'd0);

        // Soft reset of domains 1 and 3; a mask change after acceptance is ignored.
        soft_req_i  = 1'b1;
        soft_mask_i = 4'b1010;
        e           = edge_n + 1;
        and_acc     = 4'hF;
        tick();
        soft_mask_i = 4'b0101;
        apply('{0,  4'b0101, 1'b0, 1'b1, 1'b0}, e, "m1010");
        apply('{7,  4'b0101, 1'b0, 1'b1, 1'b0}, e, "m1010");
        apply('{8,  4'b0111, 1'b0, 1'b1, 1'b0}, e, "m1010");
        apply('{23, 4'b0111, 1'b0, 1'b1, 1'b0}, e, "m1010");
        apply('{24, 4'b1111, 1'b1, 1'b1, 1'b1}, e, "m1010");
        soft_req_i = 1'b0;
        apply('{25, 4'b1111, 1'b1, 1'b0, 1'b0}, e, "m1010");
        chk("m1010 low bits seen", 32'(and_acc), 32'h5);
        chk("m1010 ack count", 32'(ack_cnt), 32'd1);

        // Zero mask, request held long after ack, then re-raised after one low cycle.
        soft_req_i  = 1'b1;
        soft_mask_i = 4'b0000;
        e           = edge_n + 1;
        apply('{0,  4'b1111, 1'b1, 1'b1, 1'b1}, e, "m0000");
        apply('{1,  4'b1111, 1'b1, 1'b1, 1'b0}, e, "m0000");
        apply('{50, 4'b1111, 1'b1, 1'b1, 1'b0}, e, "m0000");
        chk("held req single ack", 32'(ack_cnt), 32'd2);
        soft_req_i = 1'b0;
        apply('{51, 4'b1111, 1'b1, 1'b0, 1'b0}, e, "m0000");
        soft_req_i  = 1'b1;
        soft_mask_i = 4'b0100;
        apply('{52, 4'b1011, 1'b0, 1'b1, 1'b0}, e, "rearm");
        apply('{59, 4'b1011, 1'b0, 1'b1, 1'b0}, e, "rearm");
        apply('{60, 4'b1111, 1'b1, 1'b1, 1'b1}, e, "rearm");
        soft_req_i = 1'b0;
        apply('{61, 4'b1111, 1'b1, 1'b0, 1'b0}, e, "rearm");
        chk("rearm ack count", 32'(ack_cnt), 32'd3);

        // Power-on reset in the middle of a full-mask soft reset.
        soft_req_i  = 1'b1;
        soft_mask_i = 4'b1111;
        e           = edge_n + 1;
        apply('{0,  4'b0000, 1'b0, 1'b1, 1'b0}, e, "m1111");
        apply('{8,  4'b0001, 1'b0, 1'b1, 1'b0}, e, "m1111");
        apply('{12, 4'b0001, 1'b0, 1'b1, 1'b0}, e, "m1111");
        soft_req_i = 1'b0;
        do_reset();
        run_por("por2");
        chk("abort no ack", 32'(ack_cnt), 32'd3);

        // Request held from edge 50 is ignored until RUN, then accepted on edge 149.
        do_reset();
        req_set = 1'b0;
        foreach (por_tbl[i]) begin
            if (!req_set && por_tbl[i].off > 49) begin
                while (edge_n < 49) tick();
                soft_req_i  = 1'b1;
                soft_mask_i = 4'b0001;
                req_set     = 1'b1;
            end
            apply(por_tbl[i], 0, "por3");
        end
        v = '{149, 4'b1110, 1'b0, 1'b1, 1'b0}; apply(v, 0, "early");
        v = '{156, 4'b1110, 1'b0, 1'b1, 1'b0}; apply(v, 0, "early");
        v = '{157, 4'b1111, 1'b1, 1'b1, 1'b1}; apply(v, 0, "early");
        soft_req_i = 1'b0;
        v = '{158, 4'b1111, 1'b1, 1'b0, 1'b0}; apply(v, 0, "early");
        chk("early ack count", 32'(ack_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Parametrised multi-domain reset sequencer for system benches and FPGA tops. It replaces the single fixed-count reset release with the following:
- N independently gated reset outputs, released in ascending index order after a power-on hold.
- A handshaked soft-reset request that re-resets a selected subset of domains and re-releases them in order.
- Fully synthesisable, so the same block serves simulation (including Verilator) and hardware tops.

Parameters:
N_RST, 4, number of reset domains (1..32)
CNT_W, 16, delay counter width; must hold max(INIT_DLY, STEP_DLY, SOFT_HOLD)
INIT_DLY, 100, clk edges from rstn deassertion to release of rstn_o[0] (>=1)
STEP_DLY, 16, clk edges between successive domain releases (>=1)
SOFT_HOLD, 8, clk edges soft-reset domains are held low (>=1)

Ports:
clk  in  1  system clock
rstn  in  1  power-on reset, asynchronous assert, active low
soft_req_i  in  1  soft-reset request, level, held until soft_ack_o
soft_mask_i  in  N_RST  domains to soft-reset, sampled with the request
rstn_o  out  N_RST  per-domain active-low resets
all_rel_o  out  1  high when every rstn_o bit is high
busy_o  out  1  high whenever state is not RUN
soft_ack_o  out  1  one-cycle soft-reset completion pulse

Behaviour:
- Reset (rstn low, asynchronous):
  - rstn_o = 0, all_rel_o = 0, soft_ack_o = 0, busy_o = 1.
  - state = PWR_HOLD, counter = 0, channel index = 0.
  - Assertion mid-sequence (including mid soft-reset) aborts immediately; no ack is issued.
- Edge numbering: edge 1 is the first rising clk edge with rstn high.
- All output deassertions, and soft-reset assertions, are synchronous to clk.
- Power-on release:
  - PWR_HOLD counts edges. rstn_o[0] rises on edge INIT_DLY.
  - State RELEASE then raises rstn_o[k] on edge INIT_DLY + k*STEP_DLY.
  - After the last release, state goes to RUN.
- all_rel_o is registered and changes on the same edge that makes &rstn_o true or false.
- busy_o falls on the edge entering RUN.
- Soft-reset acceptance:
  - A request is accepted only on an edge where state == RUN and soft_req_i == 1.
  - A request in any other state is ignored but remains pending if still held.
  - On the accepting edge E: mask := soft_mask_i; masked rstn_o bits fall; busy_o rises; all_rel_o falls.
- Zero mask: if the captured mask is 0, soft_ack_o pulses on edge E, no rstn_o changes, and state goes to WAIT_LOW.
- SOFT_HOLD state: masked bits stay low. The lowest masked index rises on edge E+SOFT_HOLD.
- SOFT_REL state:
  - Each next-higher masked index rises STEP_DLY edges after the previous masked release.
  - Unmasked indices are skipped with no delay.
- Soft-reset completion:
  - soft_ack_o is high for exactly one cycle, asserted on the edge of the last masked release.
  - State then goes to WAIT_LOW.
  - Unmasked rstn_o bits never toggle during a soft reset.
- WAIT_LOW: returns to RUN (busy_o falls) on the first edge where soft_req_i is sampled low. A held request never retriggers.
- soft_mask_i changes after edge E have no effect.
- Counter never wraps. It reloads to 0 on every state or channel transition.

Test Plan:
- POR, defaults: rstn low 3 cycles then high -> rstn_o[0..3] rise on edges 100/116/132/148; all_rel_o rises and busy_o falls on edge 148; soft_ack_o stays 0.
- Soft mask 4'b1010 accepted at edge E -> rstn_o[1],[3] fall at E; [0],[2] stay 1 throughout; [1] rises at E+8, [3] at E+24; soft_ack_o high only in cycle E+24; all_rel_o low E..E+23.
- Soft mask 4'b0000 accepted at E -> soft_ack_o pulse at E; rstn_o stays 4'hF; busy_o high until first edge with soft_req_i low.
- soft_req_i held high from edge 50 with mask 4'b0001 -> ignored during PWR_HOLD/RELEASE; accepted at edge 149; rstn_o[0] low 149..156, high at 157; ack at 157.
- Request held for 50 cycles after ack -> no second sequence; drop for 1 cycle then raise -> new sequence accepted on the first edge the request is sampled high again.
- rstn asserted at E+12 during a mask 4'b1111 soft reset -> rstn_o = 0 immediately, no ack; after release, POR timing repeats exactly as in scenario 1.
